// File: rtl/seg_scan_decoder.sv
// Read-back decoder for a 2-digit multiplexed 7-segment scan bus: settles each digit phase,
// decodes it to a nibble and publishes {hi,lo}. Optional macro SEG_DP_IGNORE_EN masks the dp bit.
module seg_scan_decoder #(
    parameter int SETTLE  = 4,
    parameter int TIMEOUT = 4096
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] digit_seg,
    input  logic [1:0] digit_cath,
    output logic [7:0] value,
    output logic       value_valid,
    output logic       seg_error,
    output logic       scan_lost
);

    localparam int CW = $clog2(SETTLE + 1);
    localparam int TW = $clog2(TIMEOUT + 1);

    function automatic logic [4:0] seg_decode(input logic [7:0] seg);
        logic [4:0] r;
        case (seg)
            8'hFC:   r = {1'b1, 4'h0};
            8'h60:   r = {1'b1, 4'h1};
            8'hDA:   r = {1'b1, 4'h2};
            8'hF2:   r = {1'b1, 4'h3};
            8'h66:   r = {1'b1, 4'h4};
            8'hB6:   r = {1'b1, 4'h5};
            8'hBE:   r = {1'b1, 4'h6};
            8'hE0:   r = {1'b1, 4'h7};
            8'hFE:   r = {1'b1, 4'h8};
            8'hF6:   r = {1'b1, 4'h9};
            8'hEE:   r = {1'b1, 4'hA};
            8'h3E:   r = {1'b1, 4'hB};
            8'h9C:   r = {1'b1, 4'hC};
            8'h7A:   r = {1'b1, 4'hD};
            8'h9E:   r = {1'b1, 4'hE};
            8'h8E:   r = {1'b1, 4'hF};
            default: r = 5'h00;
        endcase
        return r;
    endfunction

    logic [9:0]    samp_p0;
    logic [9:0]    samp_p1;
    logic [CW-1:0] cnt;
    logic [TW-1:0] to_cnt;
    logic [3:0]    lo_buf;
    logic [3:0]    hi_buf;
    logic          have_lo;
    logic          have_hi;
    logic [7:0]    seg_m;
    logic [1:0]    cath_p0;
    logic [4:0]    dec;
    logic          strobe;
    logic          cap_lo;
    logic          cap_hi;

`ifdef SEG_DP_IGNORE_EN
    assign seg_m = {samp_p0[9:3], 1'b0};
`else
    assign seg_m = samp_p0[9:2];
`endif

    assign cath_p0 = samp_p0[1:0];
    assign dec     = seg_decode(seg_m);
    // Fires only on the transition into SETTLE-1, so a long stable window captures once.
    assign strobe  = (samp_p0 == samp_p1) && (cnt == CW'(SETTLE - 2));
    assign cap_lo  = strobe && (cath_p0 == 2'b01);
    assign cap_hi  = strobe && (cath_p0 == 2'b10);

    always_ff @(posedge clk) begin
        if (rst) begin
            samp_p0     <= '0;
            samp_p1     <= '0;
            cnt         <= '0;
            to_cnt      <= '0;
            lo_buf      <= '0;
            hi_buf      <= '0;
            have_lo     <= 1'b0;
            have_hi     <= 1'b0;
            value       <= '0;
            value_valid <= 1'b0;
            seg_error   <= 1'b0;
            scan_lost   <= 1'b0;
        end else begin
            // stage p0/p1: pin sample and its predecessor
            samp_p0     <= {digit_seg, digit_cath};
            samp_p1     <= samp_p0;
            value_valid <= 1'b0;
            seg_error   <= 1'b0;

            if (samp_p0 != samp_p1)
                cnt <= '0;
            else if (cnt != CW'(SETTLE))
                cnt <= cnt + 1'b1;

            if (cap_lo || cap_hi) begin
                to_cnt    <= '0;
                scan_lost <= 1'b0;
                if (!dec[4]) begin
                    seg_error <= 1'b1;
                    if (cap_lo) have_lo <= 1'b0;
                    else        have_hi <= 1'b0;
                end else if (cap_lo) begin
                    lo_buf <= dec[3:0];
                    if (have_hi) begin
                        value       <= {hi_buf, dec[3:0]};
                        value_valid <= 1'b1;
                        have_lo     <= 1'b0;
                        have_hi     <= 1'b0;
                    end else begin
                        have_lo <= 1'b1;
                    end
                end else begin
                    hi_buf <= dec[3:0];
                    if (have_lo) begin
                        value       <= {dec[3:0], lo_buf};
                        value_valid <= 1'b1;
                        have_lo     <= 1'b0;
                        have_hi     <= 1'b0;
                    end else begin
                        have_hi <= 1'b1;
                    end
                end
            end else if (to_cnt != TW'(TIMEOUT)) begin
                to_cnt <= to_cnt + 1'b1;
                if (to_cnt == TW'(TIMEOUT - 1)) begin
                    scan_lost <= 1'b1;
                    have_lo   <= 1'b0;
                    have_hi   <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Bench for seg_scan_decoder: a pin-history reference model checked every cycle, plus
// directed scenarios with hand-computed literal expectations.
module tb_seg_scan_decoder;

    localparam int SETTLE  = 4;
    localparam int TIMEOUT = 64;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] digit_seg = 8'h00;
    logic [1:0] digit_cath = 2'b00;
    logic [7:0] value;
    logic       value_valid;
    logic       seg_error;
    logic       scan_lost;

    seg_scan_decoder #(.SETTLE(SETTLE), .TIMEOUT(TIMEOUT)) dut (
        .clk         (clk),
        .rst         (rst),
        .digit_seg   (digit_seg),
        .digit_cath  (digit_cath),
        .value       (value),
        .value_valid (value_valid),
        .seg_error   (seg_error),
        .scan_lost   (scan_lost)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int vv_seen = 0;
    int err_seen = 0;

    // Pins as seen at the most recent rising edge
    logic [7:0] smp_seg;
    logic [1:0] smp_cath;
    logic       smp_rst;
    always @(posedge clk) begin
        smp_seg  <= digit_seg;
        smp_cath <= digit_cath;
        smp_rst  <= rst;
    end

    // Reference model state
    logic [7:0] pats [16] = '{8'hFC, 8'h60, 8'hDA, 8'hF2, 8'h66, 8'hB6, 8'hBE, 8'hE0,
                              8'hFE, 8'hF6, 8'hEE, 8'h3E, 8'h9C, 8'h7A, 8'h9E, 8'h8E};
    logic [9:0] hist [SETTLE+1];
    logic [7:0] m_value;
    logic       m_vv, m_err, m_lost, m_hlo, m_hhi;
    logic [3:0] m_lo, m_hi;
    int         m_tc;

    // hist[i] is the pin sample taken i+1 edges ago; a capture happens when the last SETTLE
    // samples agree, the one before them differs, and a digit is selected.
    task automatic model_step();
        logic [9:0] cur;
        logic [7:0] seg;
        bit         same, cap, hit;
        logic [3:0] nib;
        cur = {smp_seg, smp_cath};
        if (smp_rst) begin
            for (int i = 0; i <= SETTLE; i++) hist[i] = '0;
            m_value = 8'h00; m_vv = 0; m_err = 0; m_lost = 0;
            m_hlo = 0; m_hhi = 0; m_lo = 0; m_hi = 0; m_tc = 0;
        end else begin
            same = 1;
            for (int i = 1; i < SETTLE; i++) if (hist[i] != hist[0]) same = 0;
            cap = same && (hist[SETTLE] != hist[0]) &&
                  (hist[0][1:0] == 2'b01 || hist[0][1:0] == 2'b10);
            m_vv = 0;
            m_err = 0;
            if (cap) begin
                seg = hist[0][9:2];
`ifdef SEG_DP_IGNORE_EN
                seg[0] = 1'b0;
`endif
                hit = 0;
                nib = 4'h0;
                for (int j = 0; j < 16; j++)
                    if (pats[j] == seg) begin hit = 1; nib = 4'(j); end
                m_tc = 0;
                m_lost = 0;
                if (!hit) begin
                    m_err = 1;
                    if (hist[0][1:0] == 2'b01) m_hlo = 0; else m_hhi = 0;
                end else if (hist[0][1:0] == 2'b01) begin
                    m_lo = nib;
                    if (m_hhi) begin m_value = {m_hi, m_lo}; m_vv = 1; m_hlo = 0; m_hhi = 0; end
                    else m_hlo = 1;
                end else begin
                    m_hi = nib;
                    if (m_hlo) begin m_value = {m_hi, m_lo}; m_vv = 1; m_hlo = 0; m_hhi = 0; end
                    else m_hhi = 1;
                end
            end else if (m_tc < TIMEOUT) begin
                m_tc++;
                if (m_tc == TIMEOUT) begin m_lost = 1; m_hlo = 0; m_hhi = 0; end
            end
            for (int i = SETTLE; i > 0; i--) hist[i] = hist[i-1];
            hist[0] = cur;
        end
    endtask

    // Per-cycle comparison against the model
    initial begin
        forever begin
            @(negedge clk);
            model_step();
            n_cmp++;
            if (value !== m_value || value_valid !== m_vv || seg_error !== m_err ||
                scan_lost !== m_lost) begin
                n_bad++;
                $display("FAIL model t=%0t: got value=%h vv=%b err=%b lost=%b, want value=%h vv=%b err=%b lost=%b",
                         $time, value, value_valid, seg_error, scan_lost, m_value, m_vv, m_err, m_lost);
            end
            if (value_valid === 1'b1) vv_seen++;
            if (seg_error === 1'b1) err_seen++;
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic hold(input logic [1:0] cath, input logic [7:0] seg, input int n);
        digit_cath = cath;
        digit_seg  = seg;
        repeat (n) tick();
    endtask

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    int v0, e0;

    initial begin
        // Reset
        rst = 1'b1;
        tick();
        tick();
        chk("rst_value", int'(value), 'h00);
        chk("rst_vv", int'(value_valid), 0);
        chk("rst_err", int'(seg_error), 0);
        chk("rst_lost", int'(scan_lost), 0);
        rst = 1'b0;
        hold(2'b00, 8'h00, 4);

        // Basic frame 0x37 with exact latency
        v0 = vv_seen;
        hold(2'b01, 8'hE0, 10);
        digit_cath = 2'b10;
        digit_seg  = 8'hF2;
        for (int i = 1; i <= 5; i++) begin
            tick();
            chk("lat_vv", int'(value_valid), (i == 5) ? 1 : 0);
        end
        chk("frame37", int'(value), 'h37);
        repeat (5) tick();
        chk("frame37_pulses", vv_seen - v0, 1);

        // Short glitch is ignored
        hold(2'b00, 8'h00, 6);
        v0 = vv_seen;
        hold(2'b10, 8'hF2, 3);
        hold(2'b01, 8'hFC, 10);
        hold(2'b10, 8'h60, 10);
        chk("glitch_value", int'(value), 'h10);
        chk("glitch_pulses", vv_seen - v0, 1);

        // Unrecognised pattern, then recovery
        hold(2'b00, 8'h00, 6);
        v0 = vv_seen;
        e0 = err_seen;
        hold(2'b01, 8'h00, 10);
        chk("bad_err", err_seen - e0, 1);
        chk("bad_novv", vv_seen - v0, 0);
        hold(2'b10, 8'h8E, 10);
        hold(2'b01, 8'hFE, 10);
        chk("recover_value", int'(value), 'hF8);

        // Scan loss and recovery
        hold(2'b00, 8'h00, 70);
        chk("lost_set", int'(scan_lost), 1);
        hold(2'b01, 8'hFC, 10);
        chk("lost_clear", int'(scan_lost), 0);

        // Reset discards a captured low digit
        rst = 1'b1;
        hold(2'b00, 8'h00, 1);
        rst = 1'b0;
        v0 = vv_seen;
        hold(2'b10, 8'hB6, 10);
        chk("post_rst_novv", vv_seen - v0, 0);
        chk("post_rst_value", int'(value), 'h00);
        hold(2'b01, 8'hEE, 10);
        chk("post_rst_value2", int'(value), 'h5A);

        // Same phase twice: newer nibble wins
        hold(2'b00, 8'h00, 6);
        v0 = vv_seen;
        hold(2'b01, 8'h66, 10);
        hold(2'b01, 8'h9C, 10);
        hold(2'b10, 8'h3E, 10);
        chk("overwrite_value", int'(value), 'hBC);
        chk("overwrite_pulses", vv_seen - v0, 1);

        // Decimal point handling
        hold(2'b00, 8'h00, 6);
        e0 = err_seen;
        hold(2'b01, 8'hE1, 10);
        hold(2'b10, 8'h60, 10);
        hold(2'b01, 8'hDA, 10);
`ifdef SEG_DP_IGNORE_EN
        chk("dp_err", err_seen - e0, 0);
        chk("dp_value", int'(value), 'h17);
`else
        chk("dp_err", err_seen - e0, 1);
        chk("dp_value", int'(value), 'h12);
`endif

        hold(2'b00, 8'h00, 4);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
